// File: rtl/mcu_bus_master.sv
// MCU-side initiator for the 8-bit parallel bus: queues command/data bytes,
// paces them out with a divided busclk and captures read responses.
module mcu_bus_master #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_is_data,
    input  logic       req_read,
    input  logic [7:0] req_byte,
    output logic       busclk,
    output logic [7:0] bus_out,
    output logic       command_data,
    input  logic [7:0] bus_in,
    output logic       rsp_valid,
    output logic [7:0] rsp_byte,
    output logic       busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [7:0] PH_LOAD = 8'(CLK_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_HIGH  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [7:0]    phase_q, phase_d;
    logic [7:0]    bus_out_q, bus_out_d;
    logic          cd_q, cd_d;
    logic          read_q, read_d;
    logic [7:0]    rsp_byte_q, rsp_byte_d;
    logic          rsp_pend_q, rsp_pend_d;
    logic          rsp_valid_q, rsp_valid_d;

    logic       push, pop, empty, full, last_phase;
    logic [9:0] head;

    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign push       = req_valid && !full;
    assign head       = mem_q[rd_ptr_q];
    assign last_phase = (phase_q == 8'd0);

    always_ff @(posedge sysclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_read, req_is_data, req_byte};
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = last_phase ? phase_q : phase_q - 8'd1;
        pop         = 1'b0;
        bus_out_d   = bus_out_q;
        cd_d        = cd_q;
        read_d      = read_q;
        rsp_byte_d  = rsp_byte_q;
        rsp_pend_d  = 1'b0;
        rsp_valid_d = rsp_pend_q;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: if (last_phase) state_d = S_HIGH;
            S_HIGH:  if (last_phase) state_d = S_HOLD;
            S_HOLD: begin
                if (last_phase) begin
                    // capture now, announce one cycle later
                    if (read_q) begin
                        rsp_byte_d = bus_in;
                        rsp_pend_d = 1'b1;
                    end
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = S_SETUP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            {read_d, cd_d, bus_out_d} = head;
        end
        if (state_d != state_q) begin
            phase_d = PH_LOAD;
        end
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_LOAD;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            bus_out_q   <= 8'h00;
            cd_q        <= 1'b1;
            read_q      <= 1'b0;
            rsp_byte_q  <= 8'h00;
            rsp_pend_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            bus_out_q   <= bus_out_d;
            cd_q        <= cd_d;
            read_q      <= read_d;
            rsp_byte_q  <= rsp_byte_d;
            rsp_pend_q  <= rsp_pend_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign busclk       = (state_q == S_HIGH);
    assign bus_out      = bus_out_q;
    assign command_data = cd_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_byte     = rsp_byte_q;
    assign req_ready    = !full;
    assign busy         = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_mcu_bus_master.sv
// Directed bench for mcu_bus_master: three dividers (4, 3, 255) and a
// tiny slave model on the CLK_DIV=4 instance.
module tb_mcu_bus_master;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    always #5 sysclk = ~sysclk;

    logic       rv [3];
    logic       rd [3];
    logic       rr [3];
    logic [7:0] rb [3];
    logic       rdy [3];
    logic       bclk [3];
    logic [7:0] bout [3];
    logic       cdat [3];
    logic       rspv [3];
    logic [7:0] rspb [3];
    logic       busyv [3];
    logic [7:0] slave_out = 8'h00;

    mcu_bus_master #(.CLK_DIV(4), .FIFO_DEPTH(4)) u0 (
        .sysclk(sysclk), .reset(reset),
        .req_valid(rv[0]), .req_ready(rdy[0]),
        .req_is_data(rd[0]), .req_read(rr[0]), .req_byte(rb[0]),
        .busclk(bclk[0]), .bus_out(bout[0]), .command_data(cdat[0]),
        .bus_in(slave_out), .rsp_valid(rspv[0]), .rsp_byte(rspb[0]),
        .busy(busyv[0])
    );

    mcu_bus_master #(.CLK_DIV(3), .FIFO_DEPTH(4)) u1 (
        .sysclk(sysclk), .reset(reset),
        .req_valid(rv[1]), .req_ready(rdy[1]),
        .req_is_data(rd[1]), .req_read(rr[1]), .req_byte(rb[1]),
        .busclk(bclk[1]), .bus_out(bout[1]), .command_data(cdat[1]),
        .bus_in(8'h00), .rsp_valid(rspv[1]), .rsp_byte(rspb[1]),
        .busy(busyv[1])
    );

    mcu_bus_master #(.CLK_DIV(255), .FIFO_DEPTH(4)) u2 (
        .sysclk(sysclk), .reset(reset),
        .req_valid(rv[2]), .req_ready(rdy[2]),
        .req_is_data(rd[2]), .req_read(rr[2]), .req_byte(rb[2]),
        .busclk(bclk[2]), .bus_out(bout[2]), .command_data(cdat[2]),
        .bus_in(8'h00), .rsp_valid(rspv[2]), .rsp_byte(rspb[2]),
        .busy(busyv[2])
    );

    int tests = 0;
    int fails = 0;
    int last_push = 0;

    int         cyc = 0;
    logic       bprev [3] = '{default: 1'b0};
    int         nr [3] = '{default: 0};
    int         nrsp [3] = '{default: 0};
    int         rsp_cyc [3] = '{default: 0};
    int         rise_cyc [3][64];
    logic [7:0] rise_byte [3][64];
    logic [7:0] last_cmd = 8'h00;
    logic [31:0] address = 32'h0;

    // rise at edge k is seen as pre-edge busclk at edge k+1, stamped with k
    always @(posedge sysclk) begin
        cyc <= cyc + 1;
        for (int u = 0; u < 3; u++) begin
            bprev[u] <= bclk[u];
            if (bclk[u] && !bprev[u] && nr[u] < 64) begin
                rise_cyc[u][nr[u]]  <= cyc;
                rise_byte[u][nr[u]] <= bout[u];
                nr[u] <= nr[u] + 1;
            end
            if (rspv[u]) begin
                nrsp[u]    <= nrsp[u] + 1;
                rsp_cyc[u] <= cyc;
            end
        end
        if (bclk[0] && !bprev[0]) begin
            if (!cdat[0]) begin
                last_cmd <= bout[0];
                if (bout[0] == 8'h01) slave_out <= 8'hAE;
            end else if (last_cmd == 8'h02) begin
                address <= {address[23:0], bout[0]};
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // called on a negedge; returns on the negedge after the push edge
    task automatic push(input int u, input logic d, input logic r,
                        input logic [7:0] b);
        int n;
        n = 0;
        rv[u] = 1'b1;
        rd[u] = d;
        rr[u] = r;
        rb[u] = b;
        while (!rdy[u] && n < 2000) begin
            @(negedge sysclk);
            n++;
        end
        check("push_ready", {31'd0, rdy[u]}, 1);
        @(negedge sysclk);
        last_push = cyc;
    endtask

    task automatic wait_idle(input int u, input int limit);
        int n;
        n = 0;
        while (busyv[u] && n < limit) begin
            @(negedge sysclk);
            n++;
        end
        check("idle_wait", {31'd0, busyv[u]}, 0);
        repeat (3) @(negedge sysclk);
    endtask

    task automatic burst(input int u, input int div, input int limit);
        int s, p0;
        logic [7:0] pat [5];
        pat[0] = 8'h02; pat[1] = 8'h12; pat[2] = 8'h34;
        pat[3] = 8'h56; pat[4] = 8'h78;
        s = nr[u];
        push(u, 1'b0, 1'b0, pat[0]);
        p0 = last_push;
        for (int k = 1; k < 5; k++) push(u, 1'b1, 1'b0, pat[k]);
        rv[u] = 1'b0;
        wait_idle(u, limit);
        check("burst_rises", nr[u] - s, 5);
        check("burst_first", rise_cyc[u][s] - p0, div + 1);
        for (int k = 0; k < 5; k++) begin
            check("burst_byte", {24'd0, rise_byte[u][s+k]}, {24'd0, pat[k]});
            if (k > 0) begin
                check("burst_gap", rise_cyc[u][s+k] - rise_cyc[u][s+k-1],
                      3 * div);
            end
        end
    endtask

    initial begin
        int s, r0, n0, ok, n;
        for (int u = 0; u < 3; u++) begin
            rv[u] = 1'b0;
            rd[u] = 1'b0;
            rr[u] = 1'b0;
            rb[u] = 8'h00;
        end
        reset = 1'b1;
        repeat (3) @(negedge sysclk);
        check("rst_busclk", {31'd0, bclk[0]}, 0);
        check("rst_bus_out", {24'd0, bout[0]}, 8'h00);
        check("rst_cd", {31'd0, cdat[0]}, 1);
        check("rst_rsp_valid", {31'd0, rspv[0]}, 0);
        check("rst_rsp_byte", {24'd0, rspb[0]}, 8'h00);
        check("rst_busy", {31'd0, busyv[0]}, 0);
        check("rst_ready", {31'd0, rdy[0]}, 1);
        reset = 1'b0;
        repeat (2) @(negedge sysclk);

        // single command byte
        s = nr[0];
        push(0, 1'b0, 1'b0, 8'h02);
        rv[0] = 1'b0;
        n0 = last_push;
        ok = 1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge sysclk);
            if (bout[0] !== 8'h02 || cdat[0] !== 1'b0) ok = 0;
        end
        check("t1_stable", ok, 1);
        wait_idle(0, 200);
        check("t1_rises", nr[0] - s, 1);
        check("t1_rise_at", rise_cyc[0][s] - n0, 5);

        // SET_ADDRESS + 4 data bytes into the slave model
        burst(0, 4, 500);
        check("t2_address", address, 32'h12345678);

        // GET_ID, dummy data, last with read
        s = nr[0];
        r0 = nrsp[0];
        push(0, 1'b0, 1'b0, 8'h01);
        push(0, 1'b1, 1'b0, 8'h00);
        push(0, 1'b1, 1'b1, 8'h00);
        rv[0] = 1'b0;
        wait_idle(0, 500);
        check("t3_rsp_count", nrsp[0] - r0, 1);
        check("t3_rsp_byte", {24'd0, rspb[0]}, 8'hAE);
        check("t3_rsp_at", rsp_cyc[0] - rise_cyc[0][s+2], 9);
        check("t3_rsp_low", {31'd0, rspv[0]}, 0);

        // ten entries with valid held high
        s = nr[0];
        for (int i = 0; i < 10; i++) begin
            push(0, 1'b1, 1'b0, 8'(8'hA0 + i));
            if (i == 4) check("t4_full", {31'd0, rdy[0]}, 0);
        end
        rv[0] = 1'b0;
        wait_idle(0, 1000);
        check("t4_rises", nr[0] - s, 10);
        for (int i = 0; i < 10; i++) begin
            check("t4_order", {24'd0, rise_byte[0][s+i]}, 32'hA0 + i);
        end

        // reset during HIGH of a read transfer
        r0 = nrsp[0];
        push(0, 1'b1, 1'b1, 8'h55);
        push(0, 1'b1, 1'b0, 8'h66);
        push(0, 1'b1, 1'b0, 8'h77);
        rv[0] = 1'b0;
        n = 0;
        while (!bclk[0] && n < 100) begin
            @(negedge sysclk);
            n++;
        end
        check("t5_high", {31'd0, bclk[0]}, 1);
        reset = 1'b1;
        #1;
        check("t5_async_low", {31'd0, bclk[0]}, 0);
        check("t5_busy", {31'd0, busyv[0]}, 0);
        check("t5_ready", {31'd0, rdy[0]}, 1);
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
        s = nr[0];
        repeat (40) @(negedge sysclk);
        check("t5_no_rise", nr[0] - s, 0);
        check("t5_no_rsp", nrsp[0] - r0, 0);
        check("t5_bus_out", {24'd0, bout[0]}, 8'h00);
        check("t5_cd", {31'd0, cdat[0]}, 1);
        check("t5_rsp_byte", {24'd0, rspb[0]}, 8'h00);
        check("t5_idle", {31'd0, busyv[0]}, 0);

        // divider extremes
        burst(1, 3, 500);
        burst(2, 255, 10000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mcu_bus_master.md
# mcu_bus_master

Initiator side of the 8-bit parallel MCU bus. Turns queued command/data byte requests into `busclk`/`bus_out`/`command_data` transfers toward the FPGA-side bus slave, and captures the slave's response byte when a read is requested. Used as the MCU model in system benches and as the bridge when one FPGA drives a second MSGPU over the same bus. All logic runs on `sysclk`; `busclk` is generated by an internal divider, never used as a clock.

## Interface
Parameters:
- `CLK_DIV`, default 4: sysclk cycles per bus phase. Legal range 3..255.
- `FIFO_DEPTH`, default 4: request queue depth. Must be a power of two, at least 2.

Ports:
- `sysclk` in 1: system clock. One clock domain, all state on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: queue not full. A push happens when `req_valid && req_ready`.
- `req_is_data` in 1: 1 = data byte, 0 = command byte. Driven onto `command_data`.
- `req_read` in 1: capture `bus_in` for this transfer.
- `req_byte` in 8: byte to drive.
- `busclk` out 1: bus clock to the slave.
- `bus_out` out 8: byte to the slave's `bus_in`.
- `command_data` out 1: 0 = command, 1 = data.
- `bus_in` in 8: slave's `bus_out`.
- `rsp_valid` out 1: one-cycle pulse; `rsp_byte` is valid in that cycle.
- `rsp_byte` out 8: captured response. Holds its value until the next capture.
- `busy` out 1: FSM not in IDLE, or queue non-empty.

## Operation
- Request queue:
  - FIFO_DEPTH entries of 10 bits: {read, is_data, byte}.
  - `req_ready = !full`, taken from registered state, so it does not depend combinationally on the pop.
  - Push and pop may occur in the same cycle; occupancy is then unchanged.
  - Pointers wrap modulo FIFO_DEPTH. The occupancy counter is $clog2(FIFO_DEPTH)+1 bits wide.
- Phase counter: counts CLK_DIV-1 down to 0, reloads on every state change. Width is 8 bits.
- FSM states:
  - IDLE: `busclk`=0; `bus_out` and `command_data` hold their last values. If the queue is non-empty, pop the head entry, load `bus_out`, `command_data` and the read flag, then go to SETUP.
  - SETUP (CLK_DIV cycles): `busclk`=0, data stable. Go to HIGH.
  - HIGH (CLK_DIV cycles): `busclk`=1. The slave samples on this rising edge. Go to HOLD.
  - HOLD (CLK_DIV cycles): `busclk`=0, data still stable. On the last HOLD cycle:
    - If the read flag is set, register `rsp_byte <= bus_in` and pulse `rsp_valid` on the following cycle.
    - If the queue is non-empty, pop the next entry directly into SETUP; there is no IDLE gap.
    - Otherwise go to IDLE.
- `bus_in` is captured without a synchronizer. The slave's output has been stable for at least 2*CLK_DIV-4 sysclk by the time it is sampled.
- Host-side protocol sequencing is the requester's job; this block moves bytes only:
  - A command opcode is followed by its data bytes.
  - GET_ID is followed by dummy data transfers, and the final one has `req_read`=1.

## Timing
- Reset values: `busclk` 0, `bus_out` 8'h00, `command_data` 1, `rsp_valid` 0, `rsp_byte` 8'h00, `busy` 0, `req_ready` 1. The queue is empty and the FSM is in IDLE.
- Push to first `bus_out` change (queue empty, FSM IDLE):
  - Entry written at push edge N.
  - Popped and driven at edge N+1.
  - `busclk` rises at edge N+1+CLK_DIV.
- Each byte takes exactly 3*CLK_DIV sysclk. Back-to-back rising edges of `busclk` are 3*CLK_DIV apart.
- `bus_out` and `command_data` change only on the cycle `busclk` is already low, at least CLK_DIV cycles before the rise. They stay stable for at least CLK_DIV cycles after the fall.
- `rsp_valid` is asserted 2*CLK_DIV+1 cycles after the `busclk` rise of the read transfer, for exactly 1 cycle.
- Boundary cases:
  - Full queue: `req_ready`=0 and pushes are ignored. A pop in that cycle raises `req_ready` on the next cycle.
  - Empty queue at the end of HOLD: go to IDLE with `busclk` low. `busy` drops on the same edge.
- Reset mid-transfer:
  - `busclk` goes low asynchronously and the queue is cleared.
  - The partial transfer is dropped and no `rsp_valid` is produced.

## Test plan
- Reset with `CLK_DIV`=4, then push command 8'h02:
  - `busclk` rises once, 5 cycles after the push.
  - `command_data`=0 and `bus_out`=8'h02 are stable from 4 cycles before the rise to 8 cycles after it.
- Push SET_ADDRESS (8'h02) plus four data bytes 8'h12, 8'h34, 8'h56, 8'h78 back-to-back, into the slave model:
  - Five rising edges, 12 cycles apart.
  - The slave's `address` ends at 32'h12345678.
- GET_ID (8'h01) followed by dummy data bytes, the last with `req_read`=1, against the slave:
  - `rsp_valid` pulses once.
  - `rsp_byte`=8'hAE.
- Hold `req_valid`=1 with 10 entries queued while the bus is running:
  - `req_ready` deasserts after 4 queued entries.
  - No entry is lost or duplicated.
  - The byte order on `bus_out` matches push order.
- Assert `reset` during the HIGH phase of a read transfer:
  - `busclk` goes to 0 immediately.
  - No `rsp_valid` is produced.
  - Outputs return to their reset values and the queue is empty.
- Repeat the back-to-back scenario with `CLK_DIV`=3 and `CLK_DIV`=255: rise spacing is 9 and 765 cycles respectively.
